// File: rtl/pe_stream.sv
// pe_stream: streaming, tile-aware MAC processing element for a systolic array.
// Operands and tags are forwarded east/south with one cycle of delay. Products
// are accumulated at full precision with guard bits. Each finished tile is
// rounded and saturated once, then parked in a single-entry result register.
//
// Result handshake: res_valid is asserted while the register holds a result.
// A result is consumed on any rising edge where res_valid && res_ready. Once
// asserted, res_data/res_sat stay stable until that accept, or until an accept
// coincides with a new load, in which case the new result replaces the old one.
// A tile that finishes while res_valid && !res_ready is dropped and flagged in
// err_overrun.
module pe_stream #(
    parameter int BIT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 8,
    parameter int ACC_GUARD  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BIT_WIDTH-1:0] data_north,
    input  logic [BIT_WIDTH-1:0] data_west,
    input  logic                 valid_north,
    input  logic                 valid_west,
    input  logic                 first_west,
    input  logic                 last_west,
    output logic [BIT_WIDTH-1:0] data_south,
    output logic [BIT_WIDTH-1:0] data_east,
    output logic                 valid_south,
    output logic                 valid_east,
    output logic                 first_east,
    output logic                 last_east,
    output logic [BIT_WIDTH-1:0] res_data,
    output logic                 res_sat,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 err_overrun,
    output logic                 err_align,
    input  logic                 clr_flags,
    output logic                 dbg_state
);

    localparam int PROD_W = 2 * BIT_WIDTH;
    localparam int ACC_W  = 2 * BIT_WIDTH + ACC_GUARD;
    localparam int UPR_W  = ACC_W - BIT_WIDTH + 1;

    // Half an LSB of the result, added before truncation (round half up).
    localparam logic [ACC_W-1:0] RND_HALF = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    // Input qualification.
    logic mac;
    logic misalign;
    assign mac      = valid_north & valid_west;
    assign misalign = valid_north ^ valid_west;

    // Stage 1 registers.
    logic signed [PROD_W-1:0] p_q;
    logic                     mac_q;
    logic                     first_q;
    logic                     last_q;

    // Stage 2 registers and next-state signals.
    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    fin_q, fin_d;
    logic signed [ACC_W-1:0] p_ext;

    // Stage 3 combinational rounding/saturation.
    logic signed [ACC_W-1:0] acc_rnd;
    logic signed [ACC_W-1:0] rnd_shift;
    logic [UPR_W-1:0]        rnd_upper;
    logic                    rnd_fits;
    logic [BIT_WIDTH-1:0]    sat_data;
    logic                    sat_flag;

    // Result register control.
    logic res_load;
    logic res_drop;

    assign dbg_state = state_q;

    // Unconditional one-cycle forwarding of operands, qualifiers and tags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_south  <= '0;
            data_east   <= '0;
            valid_south <= 1'b0;
            valid_east  <= 1'b0;
            first_east  <= 1'b0;
            last_east   <= 1'b0;
        end else begin
            data_south  <= data_north;
            data_east   <= data_west;
            valid_south <= valid_north;
            valid_east  <= valid_west;
            first_east  <= first_west;
            last_east   <= last_west;
        end
    end

    // Stage 1: register the full-precision signed product with its tags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_q     <= '0;
            mac_q   <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            p_q     <= $signed(data_west) * $signed(data_north);
            mac_q   <= mac;
            first_q <= first_west & mac;
            last_q  <= last_west & mac;
        end
    end

    // Stage 2 state: FSM state, accumulator and the finalize strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            fin_q   <= fin_d;
        end
    end

    // Stage 2 next state: start, restart or extend the tile sum; finalize on last.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        fin_d   = 1'b0;
        p_ext   = {{ACC_GUARD{p_q[PROD_W-1]}}, p_q};
        if (mac_q) begin
            if (state_q == S_IDLE || first_q) begin
                acc_d = p_ext;
            end else begin
                acc_d = acc_q + p_ext;
            end
            if (last_q) begin
                fin_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                state_d = S_ACCUM;
            end
        end
    end

    // Stage 3: round half up, drop the fractional bits, saturate to BIT_WIDTH.
    always_comb begin
        acc_rnd   = acc_q + RND_HALF;
        rnd_shift = acc_rnd >>> FRAC_WIDTH;
        rnd_upper = rnd_shift[ACC_W-1:BIT_WIDTH-1];
        rnd_fits  = (&rnd_upper) | (~|rnd_upper);
        sat_data  = rnd_shift[BIT_WIDTH-1:0];
        sat_flag  = 1'b0;
        if (!rnd_fits) begin
            sat_flag = 1'b1;
            if (rnd_shift[ACC_W-1]) begin
                sat_data = {1'b1, {(BIT_WIDTH-1){1'b0}}};
            end else begin
                sat_data = {1'b0, {(BIT_WIDTH-1){1'b1}}};
            end
        end
    end

    assign res_load = fin_q & (~res_valid | res_ready);
    assign res_drop = fin_q & res_valid & ~res_ready;

    // Single-entry result register with valid/ready release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_data  <= '0;
            res_sat   <= 1'b0;
            res_valid <= 1'b0;
        end else if (res_load) begin
            res_data  <= sat_data;
            res_sat   <= sat_flag;
            res_valid <= 1'b1;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

    // Sticky error flags; a set event in the clearing cycle keeps the flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_overrun <= 1'b0;
            err_align   <= 1'b0;
        end else begin
            err_overrun <= res_drop | (err_overrun & ~clr_flags);
            err_align   <= misalign | (err_align & ~clr_flags);
        end
    end

endmodule
